// File: rtl/bram_loader_pkg.sv
// bram_loader_pkg: shared types for the BRAM loader slice.
//   state_e    - loader FSM states
//   idx_width  - width of a byte index for a word of bpw bytes (never 0)
package bram_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  function automatic int idx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/bram_loader_byte_packer.sv
// bram_loader_byte_packer: packs a byte stream little-endian into W-bit words.
// Ports:
//   clk_i, rstn_i  clock, synchronous active-low reset
//   clr_i          drop any partial word and the full flag
//   push_i         byte_i is consumed this cycle
//   pop_i          consumer has taken word_o; clears full_o
//   byte_i         incoming byte
//   word_o         packed word (byte k in bits [8k+7:8k])
//   full_o         a complete word is waiting to be popped
//   last_o         this push completes the word (combinational)
module bram_loader_byte_packer
  import bram_loader_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] word_o,
  output logic         full_o,
  output logic         last_o
);

  localparam int BPW   = W / 8;
  localparam int IDX_W = idx_width(BPW);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     word_q, word_d;
  logic             full_q, full_d;

  assign last_o = push_i && (idx_q == IDX_W'(BPW - 1));
  assign word_o = word_q;
  assign full_o = full_q;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    full_d = full_q;
    if (clr_i) begin
      idx_d  = '0;
      full_d = 1'b0;
    end else begin
      if (pop_i) full_d = 1'b0;
      if (push_i) begin
        // Every byte slot is overwritten before the word is used, so no clear is needed.
        word_d[int'(idx_q)*8 +: 8] = byte_i;
        if (last_o) begin
          idx_d  = '0;
          full_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      idx_q  <= '0;
      word_q <= '0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/bram_loader.sv
// bram_loader: receives a byte stream, packs it into dataWidth_p-bit words and
// writes them to consecutive BRAM addresses, keeping a mod-256 byte checksum.
// Ports:
//   clk_i, rstn_i   clock, synchronous active-low reset
//   start_i         start a load (only honoured when idle)
//   base_addr_i     first write address, captured at start
//   word_count_i    number of words (0..2**memSize_p), captured at start
//   byte_i/byte_valid_i/byte_ready_o  byte stream handshake
//   wr_en_o/wr_addr_o/wr_data_o       BRAM write port
//   busy_o          load in progress
//   done_o          one-cycle completion pulse
//   checksum_o      mod-256 sum of bytes accepted since the last start
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic [memSize_p-1:0]   base_addr_i,
  input  logic [memSize_p:0]     word_count_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   wr_en_o,
  output logic [memSize_p-1:0]   wr_addr_o,
  output logic [dataWidth_p-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             checksum_o
);

  if ((dataWidth_p % 8) != 0 || dataWidth_p < 8) begin : g_width_chk
    $error("bram_loader: dataWidth_p must be a non-zero multiple of 8");
  end

  state_e                 state_q, state_d;
  logic [memSize_p-1:0]   addr_q, addr_d;
  logic [memSize_p:0]     cnt_q, cnt_d;
  logic [7:0]             csum_q, csum_d;
  logic                   ready_q, ready_d;
  logic                   wr_en_q, wr_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   start_ok, accept, pk_pop, pk_full, pk_last;
  logic [dataWidth_p-1:0] pk_word;

  assign start_ok = (state_q == S_IDLE) && start_i;
  // The full guard keeps an unwritten word from being overwritten even if
  // the ready timing were ever changed.
  assign accept   = byte_valid_i && ready_q && !pk_full;
  assign pk_pop   = (state_q == S_WRITE);

  bram_loader_byte_packer #(.W(dataWidth_p)) u_packer (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (start_ok),
    .push_i (accept),
    .pop_i  (pk_pop),
    .byte_i (byte_i),
    .word_o (pk_word),
    .full_o (pk_full),
    .last_o (pk_last)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          cnt_d   = word_count_i;
          csum_d  = 8'h00;
          state_d = (word_count_i == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          csum_d = csum_q + byte_i;
          if (pk_last) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;   // wraps naturally at 2**memSize_p
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == (memSize_p+1)'(1)) ? S_DONE : S_COLLECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    ready_d = (state_d == S_COLLECT);
    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d == S_COLLECT) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= 8'h00;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // addr_q holds the current address for the whole WRITE cycle and the
  // packer word is stable then, so both drive the write port directly.
  assign byte_ready_o = ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = addr_q;
  assign wr_data_o    = pk_word;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign checksum_o   = csum_q;

endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: randomized bench for bram_loader with a queue/array reference model.
module tb_bram_loader;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int BPW   = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   word_count_i = '0;
  logic [7:0]    byte_i = '0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o, wr_en_o, busy_o, done_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic [7:0]    checksum_o;

  bram_loader #(.memSize_p(AW), .dataWidth_p(DW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .word_count_i (word_count_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .checksum_o   (checksum_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // BRAM model and write log, sampled away from the rising edge.
  logic [DW-1:0] mem [DEPTH];
  int            wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (wr_en_o) begin
      wa_q.push_back(int'(wr_addr_o));
      wd_q.push_back(wr_data_o);
      mem[wr_addr_o] = wr_data_o;
    end
    if (done_o) done_cnt++;
  end

  function automatic logic [DW-1:0] ref_word(input logic [7:0] b[$], input int i);
    logic [DW-1:0] w = '0;
    for (int k = 0; k < BPW; k++) w = w | (DW'(b[i*BPW + k]) << (8*k));
    return w;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, " ctl"}, {28'd0, byte_ready_o, wr_en_o, busy_o, done_o}, 32'd0);
    check({tag, " addr"}, 32'(wr_addr_o), 32'd0);
    check({tag, " data"}, 32'(wr_data_o), 32'd0);
    check({tag, " csum"}, 32'(checksum_o), 32'd0);
  endtask

  // One complete load: random valid gaps, optional stray start pulses mid-load.
  task automatic run_load(input string tag, input logic [AW-1:0] base, input int count,
                          input logic [7:0] bytes[$], input int gap_pct, input bit restart);
    int         nb = count * BPW;
    int         idx = 0;
    int         cyc = 0;
    int         w0, d0, nw;
    logic [7:0] sum = 8'h00;
    w0 = wa_q.size();
    d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = base; word_count_i = (AW+1)'(count);
    @(negedge clk);
    start_i = 1'b0; base_addr_i = AW'($urandom); word_count_i = (AW+1)'($urandom);
    while (idx < nb && cyc < nb*20 + 100) begin
      byte_valid_i = ($urandom_range(99) >= gap_pct);
      byte_i       = byte_valid_i ? bytes[idx] : 8'($urandom);
      start_i      = restart && busy_o && ($urandom_range(7) == 0);
      if (byte_valid_i && byte_ready_o) idx++;
      @(negedge clk);
      cyc++;
    end
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    if (idx < nb) check({tag, " timeout"}, 32'(idx), 32'(nb));
    repeat (4) @(negedge clk);
    for (int i = 0; i < nb; i++) sum = sum + bytes[i];
    nw = wa_q.size() - w0;
    check({tag, " nwrites"}, 32'(nw), 32'(count));
    for (int i = 0; i < count && i < nw; i++) begin
      check($sformatf("%s addr%0d", tag, i), 32'(wa_q[w0+i]), 32'((int'(base) + i) % DEPTH));
      check($sformatf("%s data%0d", tag, i), 32'(wd_q[w0+i]), 32'(ref_word(bytes, i)));
    end
    check({tag, " done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " csum"}, 32'(checksum_o), 32'(sum));
    check({tag, " busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [AW-1:0] b;
    int n, w0, d0, acc, cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rstn_i = 1'b1;
    @(negedge clk);

    // Reset mid-load: one word written, second word partial when reset hits
    w0 = wa_q.size();
    start_i = 1'b1; base_addr_i = 8'h40; word_count_i = 9'd3;
    @(negedge clk);
    start_i = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 50) begin
      byte_valid_i = 1'b1;
      byte_i = 8'hA0 + 8'(acc);
      if (byte_ready_o) acc++;
      @(negedge clk);
      cyc++;
    end
    byte_valid_i = 1'b0;
    check("rstmid accepted", 32'(acc), 32'd3);
    check("rstmid prewrites", 32'(wa_q.size() - w0), 32'd1);
    rstn_i = 1'b0;
    w0 = wa_q.size();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_zero($sformatf("rstmid c%0d", i));
    end
    rstn_i = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid nowrite", 32'(wa_q.size() - w0), 32'd0);
    check("rstmid nodone", 32'(done_cnt - d0), 32'd0);
    check("rstmid idle", {30'd0, busy_o, byte_ready_o}, 32'd0);

    // Basic load
    q = {8'h34, 8'h12, 8'h78, 8'h56};
    run_load("basic", 8'h10, 2, q, 0, 1'b0);
    check("basic csum14", 32'(checksum_o), 32'h14);

    // Address wrap
    q.delete();
    for (int i = 0; i < 2*BPW; i++) q.push_back(8'($urandom));
    run_load("wrap", 8'hFF, 2, q, 20, 1'b0);

    // Zero count: done right after start, no writes, checksum cleared
    w0 = wa_q.size();
    d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 8'h33; word_count_i = 9'd0;
    @(negedge clk);
    start_i = 1'b0;
    check("zero done", 32'(done_o), 32'd1);
    check("zero busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("zero donefall", 32'(done_o), 32'd0);
    repeat (2) @(negedge clk);
    check("zero csum", 32'(checksum_o), 32'd0);
    check("zero nowrite", 32'(wa_q.size() - w0), 32'd0);
    check("zero onedone", 32'(done_cnt - d0), 32'd1);

    // Back-pressure gaps plus stray start pulses, several random loads
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(6, 1);
      b = AW'($urandom);
      q.delete();
      for (int i = 0; i < n*BPW; i++) q.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", t), b, n, q, 40, 1'b1);
    end

    // Full fill, then read every location back from the BRAM model
    b = AW'($urandom);
    q.delete();
    for (int i = 0; i < DEPTH*BPW; i++) q.push_back(8'($urandom));
    run_load("full", b, DEPTH, q, 10, 1'b1);
    for (int a = 0; a < DEPTH; a++)
      check($sformatf("readback %0d", a), 32'(mem[a]),
            32'(ref_word(q, (a - int'(b) + DEPTH) % DEPTH)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
